// File: rtl/seven_seg_scanner.sv
// Self-timed multiplexed seven-segment driver with blanking gap, per-digit PWM
// dimming, leading-zero blanking and frame-synchronous double-buffered display data.
module seven_seg_scanner #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_GAP      = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit COM_ACTIVE_LOW = 1'b1
) (
    input  logic                                                     clk,
    input  logic                                                     rst_n,
    input  logic [4*NUM_DIGITS-1:0]                                  digits_in,
    input  logic [NUM_DIGITS-1:0]                                    dp_in,
    input  logic [NUM_DIGITS-1:0]                                    en_in,
    input  logic                                                     load,
    input  logic                                                     lzb_en,
    input  logic [3:0]                                               brightness,
    output logic [6:0]                                               seg,
    output logic                                                     seg_dp,
    output logic [NUM_DIGITS-1:0]                                    com,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0]   scan_idx,
    output logic                                                     frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2((SCAN_DIV > BLANK_GAP) ? SCAN_DIV : BLANK_GAP);

    typedef enum logic {
        ST_GAP,
        ST_ON
    } state_t;

    localparam state_t              ST_START = (BLANK_GAP > 0) ? ST_GAP : ST_ON;
    localparam logic [CNT_W-1:0]    ON_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]    GAP_LAST = CNT_W'(BLANK_GAP - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] COM_OFF = {NUM_DIGITS{COM_ACTIVE_LOW}};
    localparam logic [6:0]          SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic                DP_OFF   = SEG_ACTIVE_LOW;

    state_t                        state;
    logic [CNT_W-1:0]              cnt;
    logic [IDX_W-1:0]              idx;

    logic [NUM_DIGITS-1:0][3:0]    stg_dig;
    logic [NUM_DIGITS-1:0]         stg_dp;
    logic [NUM_DIGITS-1:0]         stg_en;
    logic                          pending;
    logic [NUM_DIGITS-1:0][3:0]    sh_dig;
    logic [NUM_DIGITS-1:0]         sh_dp;
    logic [NUM_DIGITS-1:0]         sh_en;

    logic                          at_boundary;
    logic [NUM_DIGITS-1:0]         lz_blank;
    logic                          zero_above;
    logic                          visible;
    logic                          lit;
    logic [NUM_DIGITS-1:0]         com_ah;
    logic [6:0]                    seg_ah;
    logic                          dp_ah;

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'b1111110;
            4'h1: decode = 7'b0110000;
            4'h2: decode = 7'b1101101;
            4'h3: decode = 7'b1111001;
            4'h4: decode = 7'b0110011;
            4'h5: decode = 7'b1011011;
            4'h6: decode = 7'b1011111;
            4'h7: decode = 7'b1110000;
            4'h8: decode = 7'b1111111;
            4'h9: decode = 7'b1111011;
            4'hA: decode = 7'b1110111;
            4'hB: decode = 7'b0011111;
            4'hC: decode = 7'b1001110;
            4'hD: decode = 7'b0111101;
            4'hE: decode = 7'b1001111;
            default: decode = 7'b1000111;
        endcase
    endfunction

    assign at_boundary = (state == ST_ON) && (cnt == ON_LAST) && (idx == IDX_LAST);

    // Walk from the most significant digit down, blanking while every digit so far is zero with no dp.
    always_comb begin
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            zero_above = zero_above && (sh_dig[NUM_DIGITS-1-j] == 4'd0) && !sh_dp[NUM_DIGITS-1-j];
            lz_blank[NUM_DIGITS-1-j] = zero_above;
        end
        lz_blank[0] = 1'b0;
    end

    // During ON the slot counter starts at 0, so its low nibble doubles as the wrapping PWM phase.
    always_comb begin
        visible = sh_en[idx] && !(lzb_en && lz_blank[idx]);
        lit     = (state == ST_ON) && visible && ((brightness == 4'hF) || (cnt[3:0] < brightness));
        com_ah  = lit ? (NUM_DIGITS'(1) << idx) : '0;
        seg_ah  = lit ? decode(sh_dig[idx]) : '0;
        dp_ah   = lit && sh_dp[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_START;
            cnt        <= '0;
            idx        <= '0;
            com        <= COM_OFF;
            seg        <= SEG_OFF;
            seg_dp     <= DP_OFF;
            scan_idx   <= '0;
            frame_done <= 1'b0;
        end else begin
            com        <= com_ah ^ COM_OFF;
            seg        <= seg_ah ^ SEG_OFF;
            seg_dp     <= dp_ah ^ DP_OFF;
            scan_idx   <= idx;
            frame_done <= at_boundary;
            case (state)
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= ST_ON;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == ON_LAST) begin
                        cnt   <= '0;
                        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        state <= ST_START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // A load on the boundary cycle re-arms pending, so it survives the swap that consumes the older staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_dig <= '0;
            stg_dp  <= '0;
            stg_en  <= '0;
            pending <= 1'b0;
            sh_dig  <= '0;
            sh_dp   <= '0;
            sh_en   <= '0;
        end else begin
            if (at_boundary && pending) begin
                sh_dig <= stg_dig;
                sh_dp  <= stg_dp;
                sh_en  <= stg_en;
            end
            if (load) begin
                stg_dig <= digits_in;
                stg_dp  <= dp_in;
                stg_en  <= en_in;
                pending <= 1'b1;
            end else if (at_boundary) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner: a cycle-position reference model predicts
// every pin of an active-low instance and an active-high instance each cycle.
module tb_seven_seg_scanner;

    localparam int ND    = 4;
    localparam int SDIV  = 16;
    localparam int GAP   = 2;
    localparam int SLOT  = GAP + SDIV;
    localparam int FRAME = ND * SLOT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   digits_in = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    en_in = '0;
    logic          load = 1'b0;
    logic          lzb_en = 1'b0;
    logic [3:0]    brightness = 4'hF;

    logic [6:0]    seg_a, seg_h;
    logic          dp_a, dp_h;
    logic [3:0]    com_a, com_h;
    logic [1:0]    idx_a, idx_h;
    logic          fd_a, fd_h;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state: cycle position since reset plus staging/shadow contents
    int            k = 0;
    logic [15:0]   m_dig = '0, s_dig = '0;
    logic [3:0]    m_dp = '0, m_en = '0, s_dp = '0, s_en = '0;
    logic          m_pend = 1'b0;

    logic [6:0] dec_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    seven_seg_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SDIV), .BLANK_GAP(GAP),
                        .SEG_ACTIVE_LOW(1'b1), .COM_ACTIVE_LOW(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .en_in(en_in),
        .load(load), .lzb_en(lzb_en), .brightness(brightness),
        .seg(seg_a), .seg_dp(dp_a), .com(com_a), .scan_idx(idx_a), .frame_done(fd_a));

    seven_seg_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SDIV), .BLANK_GAP(GAP),
                        .SEG_ACTIVE_LOW(1'b0), .COM_ACTIVE_LOW(1'b0)) u_inv (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .en_in(en_in),
        .load(load), .lzb_en(lzb_en), .brightness(brightness),
        .seg(seg_h), .seg_dp(dp_h), .com(com_h), .scan_idx(idx_h), .frame_done(fd_h));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t k=%0d)", tag, got, exp, $time, k);
        end
    endtask

    task automatic model_reset();
        k = 0;
        m_dig = '0; m_dp = '0; m_en = '0;
        s_dig = '0; s_dp = '0; s_en = '0;
        m_pend = 1'b0;
    endtask

    // Predict the outputs produced by the coming edge, advance the model, then compare.
    task automatic tick();
        int p, d, s, pwm;
        logic lit, blank;
        logic [3:0] ecom, ecom_n;
        logic [6:0] eseg, eseg_n;
        logic edp, edp_n, efd;
        logic [1:0] eidx;
        ecom = '0; eseg = '0; edp = 1'b0; efd = 1'b0; eidx = '0;
        if (rst_n) begin
            p = k % FRAME;
            d = p / SLOT;
            s = p % SLOT;
            lit = 1'b0;
            if (s >= GAP) begin
                pwm   = (s - GAP) % 16;
                blank = lzb_en && (d > 0) && ((m_dig >> (4 * d)) == 16'd0) && ((m_dp >> d) == 4'd0);
                lit   = m_en[d] && !blank && (brightness == 4'hF || pwm < int'(brightness));
            end
            if (lit) begin
                ecom = 4'(1 << d);
                eseg = dec_tab[m_dig[4*d +: 4]];
                edp  = m_dp[d];
            end
            eidx = 2'(d);
            efd  = (p == FRAME - 1);
            if (p == FRAME - 1 && m_pend) begin
                m_dig = s_dig; m_dp = s_dp; m_en = s_en;
                m_pend = 1'b0;
            end
            if (load) begin
                s_dig = digits_in; s_dp = dp_in; s_en = en_in;
                m_pend = 1'b1;
            end
            k++;
        end
        ecom_n = ~ecom;
        eseg_n = ~eseg;
        edp_n  = ~edp;
        @(posedge clk);
        #1;
        check("com_lo", 32'(com_a), 32'(ecom_n));
        check("seg_lo", 32'(seg_a), 32'(eseg_n));
        check("dp_lo", 32'(dp_a), 32'(edp_n));
        check("scan_idx", 32'(idx_a), 32'(eidx));
        check("frame_done", 32'(fd_a), 32'(efd));
        check("com_hi", 32'(com_h), 32'(ecom));
        check("seg_hi", 32'(seg_h), 32'(eseg));
        check("dp_hi", 32'(dp_h), 32'(edp));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_pos(input int target);
        for (int i = 0; i < FRAME && (k % FRAME) != target; i++) tick();
        check("wait_pos", 32'(k % FRAME), 32'(target));
    endtask

    task automatic pulse_load(input logic [15:0] dig, input logic [3:0] dp, input logic [3:0] en);
        digits_in = dig; dp_in = dp; en_in = en;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic measure(output int on_cnt, output int fd_cnt);
        on_cnt = 0;
        fd_cnt = 0;
        repeat (FRAME) begin
            tick();
            on_cnt += $countones(~com_a);
            fd_cnt += int'(fd_a);
        end
    endtask

    initial begin
        int on_cnt, fd_cnt, nz;
        model_reset();
        run(3);
        rst_n = 1'b1;

        pulse_load(16'h1234, 4'h0, 4'hF);
        run(2 * FRAME);

        wait_pos(10);
        pulse_load(16'h00A0, 4'h0, 4'hF);
        run(20);
        pulse_load(16'h0005, 4'h0, 4'hF);
        run(2 * FRAME);

        lzb_en = 1'b1;
        run(FRAME);
        pulse_load(16'h0005, 4'b0100, 4'hF);
        run(2 * FRAME);

        lzb_en = 1'b0;
        brightness = 4'd4;
        pulse_load(16'h1234, 4'h0, 4'hF);
        run(2 * FRAME);
        measure(on_cnt, fd_cnt);
        check("pwm4_on_cycles", 32'(on_cnt), 32'(4 * ND));
        check("pwm4_frame_done", 32'(fd_cnt), 32'd1);
        brightness = 4'd0;
        measure(on_cnt, fd_cnt);
        check("pwm0_on_cycles", 32'(on_cnt), 32'd0);
        brightness = 4'hF;
        measure(on_cnt, fd_cnt);
        check("pwm15_on_cycles", 32'(on_cnt), 32'(SDIV * ND));

        pulse_load(16'h1234, 4'h0, 4'b1010);
        run(2 * FRAME);

        wait_pos(FRAME - 1);
        pulse_load(16'h9876, 4'b0001, 4'hF);
        run(2 * FRAME);

        for (int i = 0; i < 1500; i++) begin
            load = ($urandom_range(0, 29) == 0);
            if (load) begin
                nz = $urandom_range(0, 4);
                digits_in = (nz == 0) ? 16'h0 : 16'($urandom & ((1 << (4 * nz)) - 1));
                dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                en_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            end
            if ($urandom_range(0, 39) == 0) brightness = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) lzb_en = ~lzb_en;
            tick();
        end
        load = 1'b0;
        brightness = 4'hF;

        pulse_load(16'h4321, 4'h0, 4'hF);
        run(2 * FRAME);
        wait_pos(2 * SLOT + GAP + 5);
        pulse_load(16'hBEEF, 4'hF, 4'hF);
        rst_n = 1'b0;
        #1;
        check("rst_async_com_lo", 32'(com_a), 32'hF);
        check("rst_async_seg_lo", 32'(seg_a), 32'h7F);
        check("rst_async_dp_lo", 32'(dp_a), 32'h1);
        check("rst_async_idx", 32'(idx_a), 32'h0);
        check("rst_async_com_hi", 32'(com_h), 32'h0);
        check("rst_async_seg_hi", 32'(seg_h), 32'h0);
        model_reset();
        run(2);
        rst_n = 1'b1;
        run(3 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete (compared %0d)", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
